// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480 timing, 12-bit colour constants, pattern encodings.
package vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [11:0] RGB_WHITE   = 12'hFFF;
    localparam logic [11:0] RGB_YELLOW  = 12'hFF0;
    localparam logic [11:0] RGB_CYAN    = 12'h0FF;
    localparam logic [11:0] RGB_GREEN   = 12'h0F0;
    localparam logic [11:0] RGB_MAGENTA = 12'hF0F;
    localparam logic [11:0] RGB_RED     = 12'hF00;
    localparam logic [11:0] RGB_BLUE    = 12'h00F;
    localparam logic [11:0] RGB_BLACK   = 12'h000;
    localparam logic [11:0] RGB_BOX_BG  = 12'h008;

    localparam logic [1:0] PAT_BARS    = 2'd0;
    localparam logic [1:0] PAT_CHECKER = 2'd1;
    localparam logic [1:0] PAT_BOX     = 2'd2;
    localparam logic [1:0] PAT_WHITE   = 2'd3;

    function automatic logic [11:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return RGB_WHITE;
            3'd1:    return RGB_YELLOW;
            3'd2:    return RGB_CYAN;
            3'd3:    return RGB_GREEN;
            3'd4:    return RGB_MAGENTA;
            3'd5:    return RGB_RED;
            3'd6:    return RGB_BLUE;
            default: return RGB_BLACK;
        endcase
    endfunction
endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position/direction state, stepped once per frame_tick.
module vga_box_mover
    import vga_pkg::*;
#(
    parameter int HORZ_PIXELS = 640,
    parameter int VERT_PIXELS = 480,
    parameter int WIDTH_BITS  = 10,
    parameter int HEIGHT_BITS = 10,
    parameter int BOX_SIZE    = 32,
    parameter int BOX_STEP    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_tick,
    output logic [WIDTH_BITS-1:0]  box_x,
    output logic [HEIGHT_BITS-1:0] box_y
);
    localparam logic [WIDTH_BITS-1:0]  X_MAX  = WIDTH_BITS'(HORZ_PIXELS - BOX_SIZE);
    localparam logic [HEIGHT_BITS-1:0] Y_MAX  = HEIGHT_BITS'(VERT_PIXELS - BOX_SIZE);
    localparam logic [WIDTH_BITS-1:0]  STEP_X = WIDTH_BITS'(BOX_STEP);
    localparam logic [HEIGHT_BITS-1:0] STEP_Y = HEIGHT_BITS'(BOX_STEP);

    logic [WIDTH_BITS-1:0]  box_x_q, box_x_d;
    logic [HEIGHT_BITS-1:0] box_y_q, box_y_d;
    logic                   right_q, right_d, down_q, down_d;

    // A wall hit reverses and steps away on the same tick, so the box never dwells.
    always_comb begin
        box_x_d = box_x_q;
        box_y_d = box_y_q;
        right_d = right_q;
        down_d  = down_q;
        if (frame_tick) begin
            if (right_q && box_x_q == X_MAX) begin
                right_d = 1'b0;
                box_x_d = box_x_q - STEP_X;
            end else if (!right_q && box_x_q == '0) begin
                right_d = 1'b1;
                box_x_d = box_x_q + STEP_X;
            end else begin
                box_x_d = right_q ? box_x_q + STEP_X : box_x_q - STEP_X;
            end
            if (down_q && box_y_q == Y_MAX) begin
                down_d  = 1'b0;
                box_y_d = box_y_q - STEP_Y;
            end else if (!down_q && box_y_q == '0) begin
                down_d  = 1'b1;
                box_y_d = box_y_q + STEP_Y;
            end else begin
                box_y_d = down_q ? box_y_q + STEP_Y : box_y_q - STEP_Y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            box_x_q <= '0;
            box_y_q <= '0;
            right_q <= 1'b1;
            down_q  <= 1'b1;
        end else begin
            box_x_q <= box_x_d;
            box_y_q <= box_y_d;
            right_q <= right_d;
            down_q  <= down_d;
        end
    end

    assign box_x = box_x_q;
    assign box_y = box_y_q;
endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator with 2-cycle registered RGB and delay-matched syncs.
// Define PATTERN_GEN_BOX_EN to build the bouncing-box pattern (pattern 2).
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int HORZ_PIXELS = 640,
    parameter int VERT_PIXELS = 480,
    parameter int WIDTH_BITS  = 10,
    parameter int HEIGHT_BITS = 10,
    parameter int BOX_SIZE    = 32,
    parameter int BOX_STEP    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH_BITS-1:0]  x_loc,
    input  logic [HEIGHT_BITS-1:0] y_loc,
    input  logic                   video_active,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic [1:0]             pattern_sel,
    output logic                   hsync,
    output logic                   vsync,
    output logic [3:0]             red,
    output logic [3:0]             green,
    output logic [3:0]             blue
);
    if ((((HORZ_PIXELS - BOX_SIZE) % BOX_STEP) != 0) ||
        (((VERT_PIXELS - BOX_SIZE) % BOX_STEP) != 0)) begin : g_bad_box_params
        $error("box travel must be a multiple of BOX_STEP");
    end

    logic                   frame_tick;
    logic [WIDTH_BITS-1:0]  x_q;
    logic [HEIGHT_BITS-1:0] y_q;
    logic                   act_q, hs_q, vs_q;
    logic [1:0]             pattern_q;
    logic [WIDTH_BITS-1:0]  bar_idx;
    logic [11:0]            rgb_d, rgb_q;
    logic                   hsync_q, vsync_q;

    assign frame_tick = (x_loc == '0) && (y_loc == HEIGHT_BITS'(VERT_PIXELS));
    assign bar_idx    = x_q / WIDTH_BITS'(HORZ_PIXELS / 8);

`ifdef PATTERN_GEN_BOX_EN
    logic [WIDTH_BITS-1:0]  box_x;
    logic [HEIGHT_BITS-1:0] box_y;
    logic                   in_box;

    vga_box_mover #(
        .HORZ_PIXELS(HORZ_PIXELS), .VERT_PIXELS(VERT_PIXELS),
        .WIDTH_BITS(WIDTH_BITS),   .HEIGHT_BITS(HEIGHT_BITS),
        .BOX_SIZE(BOX_SIZE),       .BOX_STEP(BOX_STEP)
    ) u_box (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .box_x(box_x), .box_y(box_y)
    );

    // One extra bit so box_x+BOX_SIZE cannot wrap at the right/bottom edge.
    assign in_box = ({1'b0, x_q} >= {1'b0, box_x}) &&
                    ({1'b0, x_q} <  {1'b0, box_x} + (WIDTH_BITS+1)'(BOX_SIZE)) &&
                    ({1'b0, y_q} >= {1'b0, box_y}) &&
                    ({1'b0, y_q} <  {1'b0, box_y} + (HEIGHT_BITS+1)'(BOX_SIZE));
`endif

    always_comb begin
        rgb_d = RGB_BLACK;
        case (pattern_q)
            PAT_BARS:    rgb_d = (bar_idx < WIDTH_BITS'(8)) ? bar_colour(bar_idx[2:0]) : RGB_BLACK;
            PAT_CHECKER: rgb_d = (x_q[5] ^ y_q[5]) ? RGB_WHITE : RGB_BLACK;
`ifdef PATTERN_GEN_BOX_EN
            PAT_BOX:     rgb_d = in_box ? RGB_WHITE : RGB_BOX_BG;
`else
            PAT_BOX:     rgb_d = RGB_BLACK;
`endif
            default:     rgb_d = RGB_WHITE;
        endcase
        if (!act_q) rgb_d = RGB_BLACK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q       <= '0;
            y_q       <= '0;
            act_q     <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            pattern_q <= PAT_BARS;
            rgb_q     <= RGB_BLACK;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
        end else begin
            x_q     <= x_loc;
            y_q     <= y_loc;
            act_q   <= video_active;
            hs_q    <= hsync_in;
            vs_q    <= vsync_in;
            rgb_q   <= rgb_d;
            hsync_q <= hs_q;
            vsync_q <= vs_q;
            if (frame_tick) pattern_q <= pattern_sel;
        end
    end

    assign red   = rgb_q[11:8];
    assign green = rgb_q[7:4];
    assign blue  = rgb_q[3:0];
    assign hsync = hsync_q;
    assign vsync = vsync_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench: table vectors, hand sequences and a random run against a pixel-level model.
module tb_vga_pattern_gen;
    localparam int H   = 640;
    localparam int V   = 480;
    localparam int BS  = 32;
    localparam int BST = 4;
    localparam logic [13:0] RST_OUT = 14'h3000;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] x_loc, y_loc;
    logic       video_active, hsync_in, vsync_in;
    logic [1:0] pattern_sel;
    logic       hsync, vsync;
    logic [3:0] red, green, blue;

    always #20 clk = ~clk;

    vga_pattern_gen dut (
        .clk(clk), .rst(rst), .x_loc(x_loc), .y_loc(y_loc),
        .video_active(video_active), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pattern_sel(pattern_sel), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue)
    );

    int checks = 0;
    int failures = 0;

    // Model state: latched pattern, box position/direction, pending pipeline output.
    int          m_pat;
    int          bx, by;
    bit          bright, bdown;
    logic [13:0] stage_exp = RST_OUT;
    logic [13:0] out_exp;
    logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};

    function automatic logic [11:0] model_rgb(input int x, input int y, input bit act);
        if (!act) return 12'h000;
        case (m_pat)
            0: return (x / (H / 8) < 8) ? bars[x / (H / 8)] : 12'h000;
            1: return (((x / 32) % 2) != ((y / 32) % 2)) ? 12'hFFF : 12'h000;
`ifdef PATTERN_GEN_BOX_EN
            2: return (x >= bx && x < bx + BS && y >= by && y < by + BS) ? 12'hFFF : 12'h008;
`else
            2: return 12'h000;
`endif
            default: return 12'hFFF;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h (hs,vs,rgb) at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", nm, got, exp);
        end
    endtask

    // One clock: drive inputs, step the model at the edge, compare outputs 1 time unit later.
    task automatic cycle(input bit r, input int x, input int y, input bit act,
                         input bit hs, input bit vs, input int sel);
        rst = r; x_loc = 10'(x); y_loc = 10'(y); video_active = act;
        hsync_in = hs; vsync_in = vs; pattern_sel = 2'(sel);
        @(posedge clk);
        out_exp = r ? RST_OUT : stage_exp;
        if (r) begin
            m_pat = 0; bx = 0; by = 0; bright = 1; bdown = 1;
        end else if (x == 0 && y == V) begin
            m_pat = sel;
            if (bright) begin if (bx == H - BS) begin bright = 0; bx -= BST; end else bx += BST; end
            else        begin if (bx == 0)      begin bright = 1; bx += BST; end else bx -= BST; end
            if (bdown)  begin if (by == V - BS) begin bdown = 0;  by -= BST; end else by += BST; end
            else        begin if (by == 0)      begin bdown = 1;  by += BST; end else by -= BST; end
        end
        stage_exp = r ? RST_OUT : {hs, vs, model_rgb(x, y, act)};
        #1;
        chk("model", {hsync, vsync, red, green, blue}, out_exp);
    endtask

    task automatic idle(input int sel);
        cycle(0, 700, 10, 0, 1, 1, sel);
    endtask

    task automatic tick(input int sel);
        cycle(0, 0, V, 0, 1, 1, sel);
    endtask

    task automatic pix(input string nm, input int x, input int y, input int sel, input logic [11:0] exp);
        cycle(0, x, y, 1, 1, 1, sel);
        idle(sel);
        chk(nm, {hsync, vsync, red, green, blue}, {2'b11, exp});
    endtask

    typedef struct {
        bit          tick_first;
        int          x;
        int          y;
        bit          act;
        int          sel;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int first_low, last_low;
        tbl.push_back('{1'b0,  85,  10, 1'b1, 0, 12'hFF0});
        tbl.push_back('{1'b0,  85,  10, 1'b0, 0, 12'h000});
        tbl.push_back('{1'b0,   0,   0, 1'b1, 0, 12'hFFF});
        tbl.push_back('{1'b0,  79,   0, 1'b1, 0, 12'hFFF});
        tbl.push_back('{1'b0,  80,   0, 1'b1, 0, 12'hFF0});
        tbl.push_back('{1'b0, 160,   0, 1'b1, 0, 12'h0FF});
        tbl.push_back('{1'b0, 240,   0, 1'b1, 0, 12'h0F0});
        tbl.push_back('{1'b0, 320,   5, 1'b1, 0, 12'hF0F});
        tbl.push_back('{1'b0, 400,   5, 1'b1, 0, 12'hF00});
        tbl.push_back('{1'b0, 480,   5, 1'b1, 0, 12'h00F});
        tbl.push_back('{1'b0, 639, 479, 1'b1, 0, 12'h000});
        tbl.push_back('{1'b0,  85,  10, 1'b1, 1, 12'hFF0});
        tbl.push_back('{1'b1,  32,   0, 1'b1, 1, 12'hFFF});
        tbl.push_back('{1'b0,  32,  32, 1'b1, 1, 12'h000});
        tbl.push_back('{1'b0,   0,  32, 1'b1, 1, 12'hFFF});
        tbl.push_back('{1'b1, 100, 100, 1'b1, 3, 12'hFFF});
        tbl.push_back('{1'b0, 100, 100, 1'b0, 3, 12'h000});
`ifdef PATTERN_GEN_BOX_EN
        tbl.push_back('{1'b1, 600, 400, 1'b1, 2, 12'h008});
`else
        tbl.push_back('{1'b1,  31,  31, 1'b1, 2, 12'h000});
`endif

        // Reset held three cycles.
        for (int i = 0; i < 3; i++) begin
            cycle(1, 85, 10, 1, 0, 0, 0);
            chk("reset_out", {hsync, vsync, red, green, blue}, RST_OUT);
        end
        tick(0);
        idle(0);

        foreach (tbl[i]) begin
            if (tbl[i].tick_first) begin
                tick(tbl[i].sel);
                idle(tbl[i].sel);
            end
            cycle(0, tbl[i].x, tbl[i].y, tbl[i].act, 1, 1, tbl[i].sel);
            idle(tbl[i].sel);
            chk($sformatf("vec%0d", i), {hsync, vsync, red, green, blue}, {2'b11, tbl[i].exp});
        end

        // Mid-frame reset: pattern returns to bars and stays there despite pattern_sel.
        tick(1);
        cycle(0, 85, 10, 1, 1, 1, 1);
        cycle(1, 85, 10, 1, 0, 0, 1);
        chk("midrst_out", {hsync, vsync, red, green, blue}, RST_OUT);
        cycle(0, 85, 10, 1, 1, 1, 1);
        chk("midrst_flush", {hsync, vsync, red, green, blue}, RST_OUT);
        idle(1);
        chk("midrst_bars", {hsync, vsync, red, green, blue}, 14'h3FF0);

        // Sync alignment across one line.
        first_low = -1; last_low = -1;
        for (int c = 0; c < 806; c++) begin
            cycle(0, c % 800, 5, c < 640, !(c >= 656 && c <= 751), 1, 1);
            if (hsync == 1'b0) begin
                if (first_low < 0) first_low = c + 1;
                last_low = c + 1;
            end
        end
        chk_int("hsync_first_low", first_low, 658);
        chk_int("hsync_last_low", last_low, 753);

`ifdef PATTERN_GEN_BOX_EN
        // Bounce: the box starts at (0,0) and both axes advance on every tick.
        cycle(1, 0, 0, 0, 1, 1, 2);
        for (int t = 1; t <= 112; t++) tick(2);
        pix("box_y448_in", 448, 448, 2, 12'hFFF);
        pix("box_y448_above", 448, 447, 2, 12'h008);
        tick(2);
        pix("box_y444_in", 452, 444, 2, 12'hFFF);
        pix("box_y444_above", 452, 443, 2, 12'h008);
        for (int t = 114; t <= 152; t++) tick(2);
        pix("box_x608_in", 608, 288, 2, 12'hFFF);
        pix("box_x608_left", 607, 288, 2, 12'h008);
        pix("box_x608_corner", 639, 319, 2, 12'hFFF);
        tick(2);
        pix("box_x604_in", 604, 284, 2, 12'hFFF);
        pix("box_x604_right", 636, 284, 2, 12'h008);
`endif

        // Random traffic with occasional frame ticks and resets.
        for (int i = 0; i < 600; i++) begin
            int x, y;
            bit r;
            r = ($urandom_range(99) == 0);
            if ($urandom_range(14) == 0) begin
                x = 0; y = V;
            end else begin
                x = $urandom_range(799); y = $urandom_range(524);
            end
            cycle(r, x, y, (x < H) && (y < V), 1'($urandom), 1'($urandom), $urandom_range(3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
